// File: rtl/simple_bus_arbiter.sv
// rtl/simple_bus_arbiter.sv - two-requester register-bus arbiter with captured read response
// Optional round-robin arbitration when ARB_ROUND_ROBIN_EN is defined; fixed m0-first priority otherwise.
module simple_bus_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  m0Req,
  input  logic                  m1Req,
  input  logic                  m0We,
  input  logic                  m1We,
  input  logic [ADDR_WIDTH-1:0] m0Addr,
  input  logic [ADDR_WIDTH-1:0] m1Addr,
  input  logic [DATA_WIDTH-1:0] m0Wdata,
  input  logic [DATA_WIDTH-1:0] m1Wdata,
  output logic                  m0Gnt,
  output logic                  m1Gnt,
  output logic                  m0RspValid,
  output logic                  m1RspValid,
  input  logic                  m0RspReady,
  input  logic                  m1RspReady,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [DATA_WIDTH-1:0] wrData,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  output logic                  rd,
  input  logic [DATA_WIDTH-1:0] rdData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    id_q, id_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    pick_m1;
  logic                    rsp_ready;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q = 1 means m1 was served last, so m0 wins the next tie
  logic last_q, last_d;
  assign pick_m1 = m1Req && (!m0Req || !last_q);
`else
  assign pick_m1 = m1Req && !m0Req;
`endif

  assign rsp_ready = id_q ? m1RspReady : m0RspReady;
  assign rspData   = rsp_data_q;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    m0Gnt      = 1'b0;
    m1Gnt      = 1'b0;
    m0RspValid = 1'b0;
    m1RspValid = 1'b0;
    wr         = 1'b0;
    wrAddr     = '0;
    wrData     = '0;
    rd         = 1'b0;
    rdAddr     = '0;

    case (state_q)
      IDLE: begin
        if (m0Req || m1Req) begin
          m0Gnt   = !pick_m1;
          m1Gnt   = pick_m1;
          id_d    = pick_m1;
          we_d    = pick_m1 ? m1We    : m0We;
          addr_d  = pick_m1 ? m1Addr  : m0Addr;
          wdata_d = pick_m1 ? m1Wdata : m0Wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          wr         = 1'b1;
          wrAddr     = addr_q;
          wrData     = wdata_q;
          rsp_data_d = '0;
        end else begin
          rd         = 1'b1;
          rdAddr     = addr_q;
          rsp_data_d = rdData;
        end
        state_d = RESP;
      end
      RESP: begin
        m0RspValid = !id_q;
        m1RspValid = id_q;
        if (rsp_ready) begin
`ifdef ARB_ROUND_ROBIN_EN
          last_d = id_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb/tb_simple_bus_arbiter.sv - directed vector bench for simple_bus_arbiter
// Expected grant order follows ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_simple_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0Req = 0, m1Req = 0, m0We = 0, m1We = 0;
  logic [5:0]  m0Addr = 0, m1Addr = 0;
  logic [31:0] m0Wdata = 0, m1Wdata = 0;
  logic        m0Gnt, m1Gnt, m0RspValid, m1RspValid;
  logic        m0RspReady = 0, m1RspReady = 0;
  logic [31:0] rspData, wrData, rdData = 0;
  logic [5:0]  wrAddr, rdAddr;
  logic        wr, rd;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  simple_bus_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .m0Req(m0Req), .m1Req(m1Req), .m0We(m0We), .m1We(m1We),
    .m0Addr(m0Addr), .m1Addr(m1Addr), .m0Wdata(m0Wdata), .m1Wdata(m1Wdata),
    .m0Gnt(m0Gnt), .m1Gnt(m1Gnt), .m0RspValid(m0RspValid), .m1RspValid(m1RspValid),
    .m0RspReady(m0RspReady), .m1RspReady(m1RspReady), .rspData(rspData),
    .wrAddr(wrAddr), .wrData(wrData), .wr(wr), .rdAddr(rdAddr), .rd(rd), .rdData(rdData)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr && rd) overlap++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [5:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata, rd_data;
    logic        win_fixed, win_rr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic        win, we;
    logic [5:0]  addr;
    logic [31:0] wdata;
`ifdef ARB_ROUND_ROBIN_EN
    win = v.win_rr;
`else
    win = v.win_fixed;
`endif
    we    = win ? v.m1_we    : v.m0_we;
    addr  = win ? v.m1_addr  : v.m0_addr;
    wdata = win ? v.m1_wdata : v.m0_wdata;
    m0Req = v.m0_req; m1Req = v.m1_req; m0We = v.m0_we; m1We = v.m1_we;
    m0Addr = v.m0_addr; m1Addr = v.m1_addr; m0Wdata = v.m0_wdata; m1Wdata = v.m1_wdata;
    #1;
    chk($sformatf("v%0d m0Gnt", idx), m0Gnt, !win);
    chk($sformatf("v%0d m1Gnt", idx), m1Gnt, win);
    step();
    m0Req = 0; m1Req = 0; rdData = v.rd_data;
    #1;
    chk($sformatf("v%0d wr", idx), wr, we);
    chk($sformatf("v%0d rd", idx), rd, !we);
    chk($sformatf("v%0d wrAddr", idx), wrAddr, we ? addr : 6'd0);
    chk($sformatf("v%0d wrData", idx), wrData, we ? wdata : 32'd0);
    chk($sformatf("v%0d rdAddr", idx), rdAddr, we ? 6'd0 : addr);
    step();
    rdData = 32'hFFFF_0000; m0RspReady = !win; m1RspReady = win;
    #1;
    chk($sformatf("v%0d m0RspValid", idx), m0RspValid, !win);
    chk($sformatf("v%0d m1RspValid", idx), m1RspValid, win);
    chk($sformatf("v%0d rspData", idx), rspData, we ? 32'd0 : v.rd_data);
    step();
    m0RspReady = 0; m1RspReady = 0;
    #1;
    chk($sformatf("v%0d idle valids", idx), {m0RspValid, m1RspValid}, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  initial begin
    vecs[0] = '{1, 0, 1, 0, 6'h05, 6'h00, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 6'h00, 6'h0A, 32'h0, 32'h0, 32'h12345678, 1, 1};
    vecs[2] = '{1, 0, 0, 0, 6'h3F, 6'h00, 32'h0, 32'h0, 32'hA5A5A5A5, 0, 0};
    vecs[3] = '{0, 1, 0, 1, 6'h00, 6'h01, 32'h0, 32'hCAFEF00D, 32'h0, 1, 1};
    vecs[4] = '{1, 1, 1, 0, 6'h10, 6'h20, 32'h00000001, 32'h0, 32'h00000055, 0, 0};
    vecs[5] = '{1, 1, 0, 1, 6'h11, 6'h22, 32'h0, 32'h00000099, 32'h00000077, 0, 1};

    do_reset();
    chk("reset gnt", {m0Gnt, m1Gnt}, 0);
    chk("reset rspvalid", {m0RspValid, m1RspValid}, 0);
    chk("reset strobes", {wr, rd}, 0);
    chk("reset wrAddr", wrAddr, 0);
    chk("reset wrData", wrData, 0);
    chk("reset rdAddr", rdAddr, 0);
    chk("reset rspData", rspData, 0);

    step();
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // read response held through back-pressure; m0RspReady must be ignored
    step();
    m1Req = 1; m1We = 0; m1Addr = 6'h0A;
    #1 chk("stall m1Gnt", m1Gnt, 1);
    step();
    m1Req = 0; rdData = 32'h12345678;
    #1 chk("stall rd", rd, 1);
    chk("stall rdAddr", rdAddr, 6'h0A);
    for (int i = 0; i < 3; i++) begin
      step();
      rdData = $urandom; m0RspReady = 1; m1RspReady = 0;
      #1;
      chk($sformatf("stall%0d m1RspValid", i), m1RspValid, 1);
      chk($sformatf("stall%0d m0RspValid", i), m0RspValid, 0);
      chk($sformatf("stall%0d rspData", i), rspData, 32'h12345678);
    end
    step();
    m1RspReady = 1;
    #1 chk("stall release valid", m1RspValid, 1);
    step();
    m1RspReady = 0; m0RspReady = 0;
    #1 chk("stall released", m1RspValid, 0);

    // request arriving while busy waits for IDLE
    step();
    m0Req = 1; m0We = 1; m0Addr = 6'h07; m0Wdata = 32'h11;
    #1 chk("busy m0Gnt", m0Gnt, 1);
    step();
    m0Req = 0; m1Req = 1; m1We = 1; m1Addr = 6'h08; m1Wdata = 32'h22;
    #1 chk("busy access m1Gnt", m1Gnt, 0);
    chk("busy access wr", wr, 1);
    step();
    #1 chk("busy resp m1Gnt", m1Gnt, 0);
    chk("busy resp m0RspValid", m0RspValid, 1);
    step();
    m0RspReady = 1;
    #1 chk("busy resp2 m1Gnt", m1Gnt, 0);
    step();
    m0RspReady = 0;
    #1 chk("busy idle m1Gnt", m1Gnt, 1);
    step();
    m1Req = 0;
    #1 chk("busy m1 wrAddr", wrAddr, 6'h08);
    chk("busy m1 wrData", wrData, 32'h22);
    step();
    m1RspReady = 1;
    #1 chk("busy m1RspValid", m1RspValid, 1);
    step();
    m1RspReady = 0;

    // sustained contention from a fresh reset
    do_reset();
    step();
    m0Req = 1; m1Req = 1; m0We = 0; m1We = 0; m0RspReady = 1; m1RspReady = 1;
    #1;
    for (int t = 0; t < 4; t++) begin
      int cyc;
      logic exp_m1;
      cyc = 0;
      while (!(m0Gnt || m1Gnt) && cyc < 10) begin
        @(posedge clk); #2; cyc++;
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_m1 = t[0];
`else
      exp_m1 = 1'b0;
`endif
      chk($sformatf("contend%0d granted", t), m0Gnt || m1Gnt, 1);
      chk($sformatf("contend%0d winner_m1", t), m1Gnt, exp_m1);
      @(posedge clk); #2;
    end
    m0Req = 0; m1Req = 0;
    repeat (4) @(posedge clk);
    #1 m0RspReady = 0; m1RspReady = 0;

    // reset during ACCESS of a write
    step();
    m0Req = 1; m0We = 1; m0Addr = 6'h05; m0Wdata = 32'hDEADBEEF;
    #1 chk("midrst m0Gnt", m0Gnt, 1);
    step();
    m0Req = 0;
    #1 chk("midrst wr before", wr, 1);
    rst_n = 0;
    #1;
    chk("midrst wr dropped", wr, 0);
    chk("midrst wrAddr", wrAddr, 0);
    chk("midrst wrData", wrData, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk($sformatf("postrst%0d quiet", i), {wr, rd, m0RspValid, m1RspValid}, 0);
    end

    chk("wr_rd overlap cycles", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_bus_arbiter.md
# simple_bus_arbiter

Two-requester arbiter that shares one simple register bus (wrAddr/wrData/wr, rdAddr/rd/rdData) between the AXI4-Lite host port and a local requester such as a coefficient loader. It sits between the requesters and the equalizer register file. It serialises their accesses through a three-state FSM, captures read data, and returns a per-requester response with a ready/valid handshake.

## Interface
- ADDR_WIDTH, 6, register address width
- DATA_WIDTH, 32, register data width
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  reset; asynchronous assert, active-low
- m0Req, m1Req  in  1 each  request; held until the matching grant
- m0We, m1We  in  1 each  1 = write, 0 = read; valid with req
- m0Addr, m1Addr  in  ADDR_WIDTH each  access address
- m0Wdata, m1Wdata  in  DATA_WIDTH each  write data
- m0Gnt, m1Gnt  out  1 each  one-cycle grant; request fields are sampled in this cycle
- m0RspValid, m1RspValid  out  1 each  response valid (read data or write done)
- m0RspReady, m1RspReady  in  1 each  requester accepts the response
- rspData  out  DATA_WIDTH  captured read data; 0 for write responses
- wrAddr  out  ADDR_WIDTH  downstream write address
- wrData  out  DATA_WIDTH  downstream write data
- wr  out  1  downstream write strobe
- rdAddr  out  ADDR_WIDTH  downstream read address
- rd  out  1  downstream read strobe
- rdData  in  DATA_WIDTH  downstream read data; combinationally valid in the cycle rd is high

## Operation
- FSM states and transitions:
  - IDLE: if m0Req or m1Req is high, pick a winner and assert its Gnt combinationally. Latch id, we, addr and wdata into registers, then go to ACCESS. Requests are ignored in every other state.
  - ACCESS: drive the latched address on wrAddr (write) or rdAddr (read). Assert wr or rd for exactly this one cycle. On a read, register rdData into rspData; on a write, clear rspData to 0. Go to RESP.
  - RESP: hold the winner's RspValid and rspData stable. When the winner's RspReady is high, update the priority pointer and go to IDLE.
- Downstream wrAddr/wrData/rdAddr are 0 whenever the matching strobe is low.
- Winner selection: see Configuration. A lone request always wins.
- Only one downstream strobe is ever active. wr and rd are never high together.
- The requester deasserts req (or presents a new transaction) after seeing Gnt. A req still high on return to IDLE is treated as a new transaction.

## Timing
- Reset values: all outputs 0. FSM in IDLE. rspData 0. Priority pointer = m1 last served, so m0 wins the first tie.
- Asynchronous reset mid-transaction: return to IDLE at once and drop any pending strobe or response. No downstream strobe appears after the reset edge.
- Latency: req in IDLE at cycle 0 → Gnt in cycle 0, rd/wr in cycle 1, RspValid from cycle 2.
- Minimum spacing is 3 cycles per transaction when RspReady is already high in RESP. RESP stalls indefinitely while RspReady is low.
- RspReady of the non-winning requester is ignored.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration. On simultaneous requests, the requester not served last wins. The pointer updates on the RESP→IDLE transition.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, m0 always beats m1. The pointer register is removed, and m1 may starve.

## Test plan
- Reset: hold S_AXI_ARESETN low, then release → all outputs 0. A single m0 write (addr 0x05, data 0xDEADBEEF) gives m0Gnt in cycle 0, wr=1/wrAddr=0x05/wrData=0xDEADBEEF in cycle 1, and m0RspValid with rspData=0 in cycle 2.
- Read: m1 reads addr 0x0A while rdData=0x12345678 in the rd cycle → m1RspValid with rspData=0x12345678 held through 3 cycles of m1RspReady=0, released on the first cycle with m1RspReady=1.
- Contention with ARB_ROUND_ROBIN_EN: m0Req and m1Req held high for 4 transactions → grant order m0, m1, m0, m1. Without the macro → m0, m0, m0, m0.
- Request during busy: m1Req rises while in ACCESS → no m1Gnt until the FSM returns to IDLE. wr and rd are never high in the same cycle.
- Reset mid-operation: assert reset during ACCESS of a write → wr drops immediately. After release the FSM is in IDLE, with no RspValid and no repeated strobe.
